// File: rtl/sram_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache sitting
// between the MEM stage and the SRAM controller; ready=0 freezes the pipeline.
module sram_cache_controller #(
    parameter int          INDEX_BITS = 6,
    parameter logic [31:0] BASE_ADDR  = 32'd1024,
    parameter int          TAG_BITS   = 17 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);
    // state | meaning
    // IDLE  | serve read hits, accept new requests
    // RMISS | waiting for SRAM read data, then allocate
    // WRITE | waiting for SRAM write completion
    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

    localparam int SETS = 1 << INDEX_BITS;

    state_t r_state;
    state_t w_next;

    logic [SETS-1:0]     r_valid0;
    logic [SETS-1:0]     r_valid1;
    logic [SETS-1:0]     r_lru;
    logic [TAG_BITS-1:0] r_tag0  [SETS];
    logic [TAG_BITS-1:0] r_tag1  [SETS];
    logic [31:0]         r_data0 [SETS];
    logic [31:0]         r_data1 [SETS];

    logic [16:0]           w_off_word;
    logic [INDEX_BITS-1:0] w_set;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_victim;
    logic                  w_rd_hit;
    logic                  w_fill;
    logic                  w_wr_done;

    // Base is word aligned, so the subtraction only needs the word-address bits.
    assign w_off_word = address[18:2] - BASE_ADDR[18:2];
    assign w_set      = w_off_word[INDEX_BITS-1:0];
    assign w_tag      = w_off_word[16:INDEX_BITS];

    assign w_hit0   = r_valid0[w_set] && (r_tag0[w_set] == w_tag);
    assign w_hit1   = r_valid1[w_set] && (r_tag1[w_set] == w_tag);
    assign w_hit    = w_hit0 || w_hit1;
    assign w_victim = !r_valid0[w_set] ? 1'b0 :
                      !r_valid1[w_set] ? 1'b1 : r_lru[w_set];

    assign w_rd_hit  = (r_state == IDLE) && !mem_w_en && mem_r_en && w_hit;
    assign w_fill    = (r_state == RMISS) && sram_ready;
    assign w_wr_done = (r_state == WRITE) && sram_ready;

    assign sram_read_en  = (r_state == RMISS);
    assign sram_write_en = (r_state == WRITE);
    assign sram_address  = address;
    assign sram_wdata    = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_w_en) begin
                    w_next = WRITE;
                end else if (mem_r_en && !w_hit) begin
                    w_next = RMISS;
                end
            end
            RMISS:   if (sram_ready) w_next = IDLE;
            WRITE:   if (sram_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        rdata = 32'd0;
        case (r_state)
            IDLE: begin
                ready = !mem_w_en && !(mem_r_en && !w_hit);
                if (w_rd_hit) begin
                    rdata = w_hit0 ? r_data0[w_set] : r_data1[w_set];
                end
            end
            RMISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    rdata = sram_rdata;
                end
            end
            WRITE:   ready = sram_ready;
            default: ready = 1'b0;
        endcase
    end

    // LRU bit names the way to evict next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else if (w_fill) begin
            if (w_victim) begin
                r_valid1[w_set] <= 1'b1;
            end else begin
                r_valid0[w_set] <= 1'b1;
            end
            r_lru[w_set] <= ~w_victim;
        end else if (w_rd_hit || (w_wr_done && w_hit)) begin
            r_lru[w_set] <= w_hit0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_victim) begin
                r_tag1[w_set]  <= w_tag;
                r_data1[w_set] <= sram_rdata;
            end else begin
                r_tag0[w_set]  <= w_tag;
                r_data0[w_set] <= sram_rdata;
            end
        end else if (w_wr_done) begin
            if (w_hit0) begin
                r_data0[w_set] <= wdata;
            end else if (w_hit1) begin
                r_data1[w_set] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_cache_controller.sv
// Bench for sram_cache_controller: table of requests with expected data,
// latency and SRAM enable counts, plus a reset-during-miss sequence.
module tb_sram_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    always #5 clk = ~clk;

    sram_cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_read_en (sram_read_en),
        .sram_write_en(sram_write_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    // SRAM controller model: ready drops on a request, completes on the 7th enabled cycle.
    logic [31:0] mem [256];
    logic [3:0]  cnt;
    logic [7:0]  idx;

    assign idx        = sram_address[9:2];
    assign sram_rdata = mem[idx];
    assign sram_ready = !(sram_read_en || sram_write_en) || (cnt == 4'd6);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i == 0) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
            end
            cnt <= 4'd0;
        end else begin
            if (sram_write_en && sram_ready) mem[idx] <= sram_wdata;
            cnt <= (sram_read_en || sram_write_en) ? cnt + 4'd1 : 4'd0;
        end
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
        int          cycles;
        int          ren;
        int          wen;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          cycles;
        int          ren;
        int          wen;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Call just after a posedge; returns just after a posedge with the bus idle.
    task automatic run_req(input int id, input vec_t v);
        exp_t        e;
        exp_t        got_e;
        int          cyc;
        int          nr;
        int          nw;
        bit          done;
        logic [31:0] got_rdata;
        logic [31:0] got_saddr;
        logic [31:0] got_swdata;
        e.id        = id;
        e.rdata     = v.exp_rdata;
        e.chk_rdata = v.chk_rdata;
        e.cycles    = v.cycles;
        e.ren       = v.ren;
        e.wen       = v.wen;
        sb.push_back(e);
        mem_r_en = v.rd;
        mem_w_en = v.wr;
        address  = v.addr;
        wdata    = v.wd;
        cyc = 0; nr = 0; nw = 0; done = 0;
        got_rdata = '0; got_saddr = '0; got_swdata = '0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sram_read_en)  nr++;
            if (sram_write_en) nw++;
            if (ready) begin
                done       = 1;
                got_rdata  = rdata;
                got_saddr  = sram_address;
                got_swdata = sram_wdata;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout (vec %0d): ready never rose in %0d cycles", id, cyc);
            void'(sb.pop_front());
        end else begin
            got_e = sb.pop_front();
            if (got_e.chk_rdata) chk("rdata", got_e.id, got_rdata, got_e.rdata);
            chk("cycles",     got_e.id, 32'(cyc), 32'(got_e.cycles));
            chk("read_en_n",  got_e.id, 32'(nr),  32'(got_e.ren));
            chk("write_en_n", got_e.id, 32'(nw),  32'(got_e.wen));
            chk("sram_addr",  got_e.id, got_saddr,  v.addr);
            chk("sram_wdata", got_e.id, got_swdata, v.wd);
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        wdata    = 32'd0;
        @(negedge clk);
        chk("idle_ren",   id, {31'd0, sram_read_en},  32'd0);
        chk("idle_wen",   id, {31'd0, sram_write_en}, 32'd0);
        chk("idle_ready", id, {31'd0, ready},         32'd1);
        chk("idle_rdata", id, rdata,                  32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input bit crd, input int c, input int nr, input int nw);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = d; v.exp_rdata = er; v.chk_rdata = crd;
        v.cycles = c; v.ren = nr; v.wen = nw;
        return v;
    endfunction

    vec_t tmp;

    initial begin
        // rd wr addr wdata exp_rdata chk cycles ren wen
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'hDEADBEEF, 1, 8, 7, 0)); // miss -> way0
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0)); // hit
        vecs.push_back(mk(1, 0, 32'h500, 32'h0, 32'hC0DE0040, 1, 8, 7, 0)); // miss -> way1
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0)); // hit, LRU -> way1
        vecs.push_back(mk(1, 0, 32'h600, 32'h0, 32'hC0DE0080, 1, 8, 7, 0)); // evicts 0x500
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0)); // still hit
        vecs.push_back(mk(1, 0, 32'h500, 32'h0, 32'hC0DE0040, 1, 8, 7, 0)); // misses again
        vecs.push_back(mk(0, 1, 32'h400, 32'h12345678, 32'h0, 0, 8, 0, 7)); // store, hit
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'h12345678, 1, 1, 0, 0)); // updated line
        vecs.push_back(mk(0, 1, 32'h700, 32'hAAAA5555, 32'h0, 0, 8, 0, 7)); // store, miss
        vecs.push_back(mk(1, 0, 32'h700, 32'h0, 32'hAAAA5555, 1, 8, 7, 0)); // no allocate
        vecs.push_back(mk(1, 1, 32'h400, 32'h0BADF00D, 32'h0, 0, 8, 0, 7)); // write wins
        vecs.push_back(mk(1, 0, 32'h400, 32'h0, 32'h0BADF00D, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h700, 32'h0, 32'hAAAA5555, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h404, 32'h0, 32'hC0DE0001, 1, 8, 7, 0)); // set 1
        vecs.push_back(mk(1, 0, 32'h404, 32'h0, 32'hC0DE0001, 1, 1, 0, 0));

        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", -1, {31'd0, ready},         32'd1);
        chk("rst_rdata", -1, rdata,                  32'd0);
        chk("rst_ren",   -1, {31'd0, sram_read_en},  32'd0);
        chk("rst_wen",   -1, {31'd0, sram_write_en}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) run_req(i, vecs[i]);

        // Reset while a fill is outstanding: enables drop at once, nothing allocated.
        mem_r_en = 1'b1;
        address  = 32'h444;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_ren", 100, {31'd0, sram_read_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ren",   100, {31'd0, sram_read_en},  32'd0);
        chk("mid_rst_wen",   100, {31'd0, sram_write_en}, 32'd0);
        chk("mid_rst_ready", 100, {31'd0, ready},         32'd0);
        mem_r_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tmp = mk(1, 0, 32'h444, 32'h0, 32'hC0DE0011, 1, 8, 7, 0);
        run_req(101, tmp);
        tmp = mk(1, 0, 32'h444, 32'h0, 32'hC0DE0011, 1, 1, 0, 0);
        run_req(102, tmp);
        tmp = mk(1, 0, 32'h400, 32'h0, 32'hDEADBEEF, 1, 8, 7, 0); // valid bits were cleared
        run_req(103, tmp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
